// File: rtl/frame_readback.sv
// frame_readback: windowed reader for the pixel framebuffer BRAM.
//
// Walks a rectangular window x-major, issues one BRAM read per cycle and
// re-times the returned data through a small skid FIFO. Each output beat
// carries its coordinates, and the final beat of the window is flagged.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start             single-cycle request; x0/y0/win_w/win_h give the window
//   busy              high from the accepted start until done
//   done              one-cycle pulse after the last beat is accepted
//   err               one-cycle pulse when a start is rejected
//   bram_addr         registered read address (FRAME_WIDTH*y + x)
//   bram_dout         read data, valid READ_LATENCY cycles after bram_addr
//   px_valid/px_ready output stream handshake
//   px_data/x/y/last  output beat payload
//
// READ_LATENCY must be >= 1 and FIFO_DEPTH >= READ_LATENCY+1.
module frame_readback #(
    parameter int unsigned FRAME_WIDTH  = 512,
    parameter int unsigned FRAME_HEIGHT = 384,
    parameter int unsigned COORD_BITS   = 16,
    parameter int unsigned ADDR_BITS    = 18,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [COORD_BITS-1:0] x0,
    input  logic [COORD_BITS-1:0] y0,
    input  logic [COORD_BITS-1:0] win_w,
    input  logic [COORD_BITS-1:0] win_h,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_BITS-1:0]  bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  px_valid,
    input  logic                  px_ready,
    output logic [DATA_WIDTH-1:0] px_data,
    output logic [COORD_BITS-1:0] px_x,
    output logic [COORD_BITS-1:0] px_y,
    output logic                  px_last
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + READ_LATENCY + 2);
    localparam logic [COORD_BITS:0] MaxX = (COORD_BITS+1)'(FRAME_WIDTH);
    localparam logic [COORD_BITS:0] MaxY = (COORD_BITS+1)'(FRAME_HEIGHT);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e                state_q;
    logic                  busy_q, done_q, err_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [COORD_BITS-1:0] cur_x_q, cur_y_q;
    logic [COORD_BITS-1:0] x_first_q, x_last_q, y_last_q;

    // Tag delay line; stage 0 lines up with the address currently on bram_addr,
    // so stage READ_LATENCY lines up with the matching bram_dout.
    logic [READ_LATENCY:0] pipe_vld_q;
    logic [READ_LATENCY:0] pipe_last_q;
    logic [COORD_BITS-1:0] pipe_x_q [READ_LATENCY+1];
    logic [COORD_BITS-1:0] pipe_y_q [READ_LATENCY+1];

    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [COORD_BITS-1:0] fifo_x_q    [FIFO_DEPTH];
    logic [COORD_BITS-1:0] fifo_y_q    [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;
    logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]       fifo_cnt_q;

    logic [COORD_BITS:0]   x_sum, y_sum;
    logic                  bounds_ok, start_ok, start_bad;
    logic [COORD_BITS-1:0] x_end_new, y_end_new;
    logic [CntW-1:0]       inflight;
    logic                  push, pop, room, read_issue;
    logic [COORD_BITS-1:0] iss_x, iss_y, nxt_x, nxt_y, row_first, row_last;
    logic                  iss_last;

    function automatic logic [ADDR_BITS-1:0] pix_addr(input logic [COORD_BITS-1:0] x,
                                                      input logic [COORD_BITS-1:0] y);
        logic [31:0] a;
        a = FRAME_WIDTH * 32'(y) + 32'(x);
        return a[ADDR_BITS-1:0];
    endfunction

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Window validation, sums one bit wider than the coordinates.
    assign x_sum     = {1'b0, x0} + {1'b0, win_w};
    assign y_sum     = {1'b0, y0} + {1'b0, win_h};
    assign bounds_ok = (win_w != '0) && (win_h != '0) && (x_sum <= MaxX) && (y_sum <= MaxY);
    assign start_ok  = start && (state_q == StIdle) && bounds_ok;
    assign start_bad = start && (state_q == StIdle) && !bounds_ok;
    assign x_end_new = x0 + win_w - COORD_BITS'(1);
    assign y_end_new = y0 + win_h - COORD_BITS'(1);

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= READ_LATENCY; i++) begin
            inflight = inflight + CntW'(pipe_vld_q[i]);
        end
    end

    assign push = pipe_vld_q[READ_LATENCY];
    assign pop  = (fifo_cnt_q != '0) && px_ready;
    // A pop this cycle frees a slot, which keeps 1 beat/cycle under steady flow
    // while still bounding inflight + stored at FIFO_DEPTH after the edge.
    assign room = (inflight + fifo_cnt_q) < (CntW'(FIFO_DEPTH) + CntW'(pop));
    // The first read goes out on the same edge that accepts start.
    assign read_issue = start_ok || ((state_q == StRead) && room);

    always_comb begin
        iss_x     = cur_x_q;
        iss_y     = cur_y_q;
        iss_last  = (cur_x_q == x_last_q) && (cur_y_q == y_last_q);
        row_first = x_first_q;
        row_last  = x_last_q;
        if (state_q == StIdle) begin
            iss_x     = x0;
            iss_y     = y0;
            iss_last  = (win_w == COORD_BITS'(1)) && (win_h == COORD_BITS'(1));
            row_first = x0;
            row_last  = x_end_new;
        end
        nxt_x = iss_x + COORD_BITS'(1);
        nxt_y = iss_y;
        if (iss_x == row_last) begin
            nxt_x = row_first;
            nxt_y = iss_y + COORD_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            x_first_q <= '0;
            x_last_q  <= '0;
            y_last_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (read_issue) begin
                addr_q  <= pix_addr(iss_x, iss_y);
                cur_x_q <= nxt_x;
                cur_y_q <= nxt_y;
            end
            case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        x_first_q <= x0;
                        x_last_q  <= x_end_new;
                        y_last_q  <= y_end_new;
                        busy_q    <= 1'b1;
                        state_q   <= iss_last ? StDrain : StRead;
                    end else if (start_bad) begin
                        err_q <= 1'b1;
                    end
                end
                StRead: begin
                    if (read_issue && iss_last) state_q <= StDrain;
                end
                StDrain: begin
                    // The last beat is the final one issued, so its pop
                    // means FIFO and pipeline are both empty.
                    if (pop && px_last) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            pipe_vld_q <= {pipe_vld_q[READ_LATENCY-1:0], read_issue};
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Payload storage carries no reset; validity lives in the flags above.
    always_ff @(posedge clk) begin
        pipe_last_q <= {pipe_last_q[READ_LATENCY-1:0], iss_last};
        pipe_x_q[0] <= iss_x;
        pipe_y_q[0] <= iss_y;
        for (int i = 1; i <= READ_LATENCY; i++) begin
            pipe_x_q[i] <= pipe_x_q[i-1];
            pipe_y_q[i] <= pipe_y_q[i-1];
        end
        if (push) begin
            fifo_data_q[wr_ptr_q] <= bram_dout;
            fifo_x_q[wr_ptr_q]    <= pipe_x_q[READ_LATENCY];
            fifo_y_q[wr_ptr_q]    <= pipe_y_q[READ_LATENCY];
            fifo_last_q[wr_ptr_q] <= pipe_last_q[READ_LATENCY];
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_cnt_q == CntW'(FIFO_DEPTH))));

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign bram_addr = addr_q;
    assign px_valid  = (fifo_cnt_q != '0);
    assign px_data   = fifo_data_q[rd_ptr_q];
    assign px_x      = fifo_x_q[rd_ptr_q];
    assign px_y      = fifo_y_q[rd_ptr_q];
    assign px_last   = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_frame_readback.sv
// tb_frame_readback: directed self-checking bench for frame_readback.
// The BRAM model returns the low 16 bits of the address as data, two cycles
// after the address is presented.
module tb_frame_readback;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x0, y0, win_w, win_h;
    logic        busy, done, err;
    logic [17:0] bram_addr;
    logic [15:0] bram_dout;
    logic        px_valid, px_ready;
    logic [15:0] px_data, px_x, px_y;
    logic        px_last;

    frame_readback dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .win_w     (win_w),
        .win_h     (win_h),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_data   (px_data),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_last   (px_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage BRAM model.
    logic [15:0] bram_d1, bram_d2;
    always @(posedge clk) begin
        bram_d1 <= bram_addr[15:0];
        bram_d2 <= bram_d1;
    end
    assign bram_dout = bram_d2;

    typedef struct {
        int x;
        int y;
        int data;
        bit last;
        int cyc;
    } beat_t;

    beat_t beats[$];
    beat_t mb;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    done_cnt = 0, done_cyc = 0, done_busy = 0;
    int    err_cnt  = 0;
    int    valid_seen = 0;
    int    hold_viol  = 0;
    int    max_cnt    = 0;
    bit    prev_stall = 1'b0;
    logic [15:0] p_data, p_x, p_y;
    logic        p_last;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (prev_stall) begin
            if (!px_valid || px_data !== p_data || px_x !== p_x || px_y !== p_y ||
                px_last !== p_last) hold_viol++;
        end
        prev_stall = px_valid && !px_ready && !rst;
        p_data = px_data;
        p_x    = px_x;
        p_y    = px_y;
        p_last = px_last;
        if (px_valid && px_ready) begin
            mb.x    = int'(px_x);
            mb.y    = int'(px_y);
            mb.data = int'(px_data);
            mb.last = px_last;
            mb.cyc  = cyc;
            beats.push_back(mb);
        end
        if (px_valid) valid_seen++;
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = int'(busy);
        end
        if (err) err_cnt++;
        if (int'(dut.fifo_cnt_q) > max_cnt) max_cnt = int'(dut.fifo_cnt_q);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int sx, input int sy, input int sw, input int sh);
        x0    = 16'(sx);
        y0    = 16'(sy);
        win_w = 16'(sw);
        win_h = 16'(sh);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget, input bit toggle);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick(1);
            if (toggle) px_ready = ~px_ready;
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
        tick(3);
        check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    endtask

    // Expected stream for a window: x-major walk, data = low 16 bits of address.
    task automatic check_window(input string tag, input int wx, input int wy,
                                input int ww, input int wh);
        int mism;
        int ex, ey;
        mism = 0;
        check({tag, "_count"}, 64'(beats.size()), 64'(ww * wh));
        for (int k = 0; k < beats.size() && k < ww * wh; k++) begin
            ex = wx + k % ww;
            ey = wy + k / ww;
            if (beats[k].x != ex || beats[k].y != ey ||
                beats[k].data != ((512 * ey + ex) & 16'hffff) ||
                beats[k].last != (k == ww * wh - 1)) mism++;
        end
        check({tag, "_order"}, 64'(mism), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int exp_x[4] = '{0, 1, 0, 1};
    int exp_y[4] = '{0, 0, 1, 1};
    int exp_d[4] = '{0, 1, 512, 513};
    int n;
    int d0;

    initial begin
        rst = 1'b1; start = 1'b0; px_ready = 1'b0;
        x0 = '0; y0 = '0; win_w = '0; win_h = '0;
        tick(3);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_valid", 64'(px_valid), 64'd0);
        check("rst_addr", 64'(bram_addr), 64'd0);
        rst = 1'b0;
        tick(2);

        // 2x2 at origin, consumer always ready.
        px_ready = 1'b1;
        beats.delete();
        do_start(0, 0, 2, 2);
        check("t1_busy", 64'(busy), 64'd1);
        tick(2);
        check("t1_lat_early", 64'(px_valid), 64'd0);
        tick(1);
        check("t1_lat_first", 64'(px_valid), 64'd1);
        run_until_done("t1", 50, 1'b0);
        check("t1_count", 64'(beats.size()), 64'd4);
        if (beats.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("t1_x%0d", k), 64'(beats[k].x), 64'(exp_x[k]));
                check($sformatf("t1_y%0d", k), 64'(beats[k].y), 64'(exp_y[k]));
                check($sformatf("t1_d%0d", k), 64'(beats[k].data), 64'(exp_d[k]));
                check($sformatf("t1_last%0d", k), 64'(beats[k].last), 64'(k == 3));
            end
            check("t1_thruput", 64'(beats[3].cyc - beats[0].cyc), 64'd3);
            check("t1_done_lat", 64'(done_cyc - beats[3].cyc), 64'd1);
        end
        check("t1_done_busy", 64'(done_busy), 64'd0);
        check("t1_busy_after", 64'(busy), 64'd0);

        // Bottom-right corner, consumer toggling ready each cycle.
        beats.delete();
        hold_viol = 0;
        max_cnt   = 0;
        px_ready  = 1'b1;
        do_start(509, 383, 3, 1);
        run_until_done("t2", 100, 1'b1);
        px_ready = 1'b1;
        check_window("t2", 509, 383, 3, 1);
        if (beats.size() == 3) begin
            check("t2_d0", 64'(beats[0].data), 64'd65533);
            check("t2_d2", 64'(beats[2].data), 64'd65535);
        end
        check("t2_hold", 64'(hold_viol), 64'd0);
        check("t2_fifo_max", 64'(max_cnt <= 4), 64'd1);

        // Rejected starts.
        valid_seen = 0;
        d0 = err_cnt;
        do_start(510, 0, 3, 1);
        check("t3_err_xbound", 64'(err), 64'd1);
        check("t3_busy_xbound", 64'(busy), 64'd0);
        tick(1);
        check("t3_err_pulse", 64'(err), 64'd0);
        do_start(0, 0, 0, 1);
        check("t3_err_w0", 64'(err), 64'd1);
        tick(1);
        do_start(0, 380, 1, 5);
        check("t3_err_ybound", 64'(err), 64'd1);
        tick(6);
        check("t3_err_count", 64'(err_cnt - d0), 64'd3);
        check("t3_no_valid", 64'(valid_seen), 64'd0);
        check("t3_busy_idle", 64'(busy), 64'd0);

        // Full-width slab ending at the frame's last pixel.
        beats.delete();
        d0 = done_cnt;
        do_start(0, 376, 512, 8);
        run_until_done("t4", 6000, 1'b0);
        check_window("t4", 0, 376, 512, 8);
        if (beats.size() > 0) begin
            check("t4_last_x", 64'(beats[beats.size()-1].x), 64'd511);
            check("t4_last_y", 64'(beats[beats.size()-1].y), 64'd383);
            check("t4_last_flag", 64'(beats[beats.size()-1].last), 64'd1);
        end

        // Reset in the middle of a window with the consumer stalled.
        beats.delete();
        do_start(0, 0, 4, 4);
        n = 0;
        while (beats.size() < 5 && n < 50) begin
            tick(1);
            n++;
        end
        px_ready = 1'b0;
        check("t5_five_beats", 64'(beats.size()), 64'd5);
        tick(3);
        check("t5_stalled", 64'(beats.size()), 64'd5);
        check("t5_valid_stall", 64'(px_valid), 64'd1);
        rst = 1'b1;
        tick(1);
        check("t5_rst_valid", 64'(px_valid), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick(2);
        beats.delete();
        px_ready = 1'b1;
        do_start(0, 0, 1, 1);
        run_until_done("t5", 50, 1'b0);
        check_window("t5", 0, 0, 1, 1);

        // Second start while busy is ignored.
        beats.delete();
        d0 = err_cnt;
        do_start(0, 0, 3, 2);
        tick(2);
        do_start(100, 100, 1, 1);
        run_until_done("t6", 100, 1'b0);
        check_window("t6", 0, 0, 3, 2);
        check("t6_no_err", 64'(err_cnt - d0), 64'd0);
        check("t6_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
